// File: rtl/pyramid_downsample_pack_pkg.sv
// pyramid_pkg
//   Shared types and constants for the Gaussian-pyramid downsample/pack stage.
//   FSM state enum, pixel type, default tile edge and quadrant count.
package pyramid_pkg;

    localparam int PIX_W    = 8;
    localparam int TILE_D   = 4;
    localparam int NUM_QUAD = 4;
    localparam int QUAD_W   = $clog2(NUM_QUAD);

    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

endpackage

// File: rtl/pyramid_downsample_pack_ds_quad.sv
// ds_quad
//   Combinational DxD -> (D/2)x(D/2) downsampler.
//   Default build: top-left pixel of each 2x2 block.
//   PYRAMID_DOWNSAMPLE_AVG_EN defined: rounded (half-up) mean of the 2x2 block.
// Ports:
//   i_tile  DxD input tile, pixel (r,c) at r*D+c
//   o_ds    (D/2)x(D/2) result, pixel (i,j) at i*(D/2)+j
module ds_quad
    import pyramid_pkg::*;
#(
    parameter int D = TILE_D,
    parameter int W = PIX_W
) (
    input  logic [D*D-1:0][W-1:0]         i_tile,
    output logic [(D/2)*(D/2)-1:0][W-1:0] o_ds
);

    localparam int H = D / 2;

`ifdef PYRAMID_DOWNSAMPLE_AVG_EN
    for (genvar i = 0; i < H; i++) begin : g_i
        for (genvar j = 0; j < H; j++) begin : g_j
            // W+2 bits holds four W-bit pixels plus the rounding constant,
            // and the >>2 result always fits back into W bits.
            logic [W+1:0] w_sum;
            assign w_sum = (W+2)'(i_tile[(2*i)*D   + 2*j])
                         + (W+2)'(i_tile[(2*i)*D   + 2*j+1])
                         + (W+2)'(i_tile[(2*i+1)*D + 2*j])
                         + (W+2)'(i_tile[(2*i+1)*D + 2*j+1])
                         + (W+2)'(2);
            assign o_ds[i*H+j] = w_sum[W+1:2];
        end
    end
`else
    for (genvar i = 0; i < H; i++) begin : g_i
        for (genvar j = 0; j < H; j++) begin : g_j
            assign o_ds[i*H+j] = i_tile[(2*i)*D + 2*j];
        end
    end

    // Only the top-left pixel of each block is consumed in this build.
    logic w_unused_pix;
    assign w_unused_pix = ^i_tile;
`endif

endmodule

// File: rtl/pyramid_downsample_pack.sv
// pyramid_downsample_pack
//   Ready-valid stage after Conv2D: downsamples each DxD tile by 2 in both
//   dimensions and packs four consecutive results into one DxD output tile
//   (quadrant 0 top-left, 1 top-right, 2 bottom-left, 3 bottom-right).
//   Optional macro PYRAMID_DOWNSAMPLE_AVG_EN selects 2x2 averaging instead of
//   top-left pick (handled in ds_quad; handshake identical in both builds).
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   valid_i      upstream tile valid
//   ready_i      stage accepts a tile (combinational from ready_o when FULL)
//   in           DxD input tile, pixel (r,c) at r*D+c
//   valid_o      packed tile valid
//   ready_o      downstream accepts the packed tile
//   out          packed DxD tile, same indexing
module pyramid_downsample_pack
    import pyramid_pkg::*;
#(
    parameter int D = TILE_D,
    parameter int W = PIX_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_i,
    output logic                 ready_i,
    input  logic [D*D-1:0][W-1:0] in,
    output logic                 valid_o,
    input  logic                 ready_o,
    output logic [D*D-1:0][W-1:0] out
);

    localparam int H = D / 2;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [QUAD_W-1:0]          r_q;
    logic [QUAD_W-1:0]          w_q_nxt;
    logic [D*D-1:0][W-1:0]      r_out;
    logic [D*D-1:0][W-1:0]      w_out_nxt;
    logic [H*H-1:0][W-1:0]      w_ds;
    logic                       w_in_txn;

    ds_quad #(.D(D), .W(W)) u_ds (
        .i_tile (in),
        .o_ds   (w_ds)
    );

    assign w_in_txn = valid_i & ready_i;

    // Each output pixel belongs to one fixed quadrant; it loads from the
    // downsampler only when that quadrant is the one being written.
    // In FULL r_q is 0, so a same-cycle refill lands in quadrant 0.
    for (genvar r = 0; r < D; r++) begin : g_r
        for (genvar c = 0; c < D; c++) begin : g_c
            localparam int QI = (r / H) * 2 + (c / H);
            localparam int DI = (r % H) * H + (c % H);
            assign w_out_nxt[r*D+c] = (w_in_txn && (r_q == QUAD_W'(QI)))
                                      ? w_ds[DI] : r_out[r*D+c];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FILL;
            r_q     <= '0;
            r_out   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_out   <= w_out_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        valid_o     = 1'b0;
        ready_i     = 1'b1;
        case (r_state)
            FILL: begin
                if (w_in_txn) begin
                    if (r_q == QUAD_W'(NUM_QUAD-1)) begin
                        w_q_nxt     = '0;
                        w_state_nxt = FULL;
                    end else begin
                        w_q_nxt = r_q + QUAD_W'(1);
                    end
                end
            end
            FULL: begin
                valid_o = 1'b1;
                // Draining frees the register this cycle, so a new tile can
                // be taken at the same edge.
                ready_i = ready_o;
                if (ready_o) begin
                    w_state_nxt = FILL;
                    w_q_nxt     = valid_i ? QUAD_W'(1) : '0;
                end
            end
            default: begin
                w_state_nxt = FILL;
                w_q_nxt     = '0;
            end
        endcase
    end

    assign out = r_out;

`ifndef SYNTHESIS
    logic                  r_chk_hold;
    logic [D*D-1:0][W-1:0] r_chk_out;

    always_ff @(posedge clk) begin
        r_chk_hold <= !reset && valid_o && !ready_o;
        r_chk_out  <= out;
        if (!reset && r_chk_hold && (!valid_o || out != r_chk_out))
            $error("pyramid_downsample_pack: output changed while stalled");
    end
`endif

endmodule

// File: tb/tb_pyramid_downsample_pack.sv
module tb_pyramid_downsample_pack;

    typedef logic [15:0][7:0] tile_t;

    logic  clk = 1'b0;
    logic  reset = 1'b1;
    logic  valid_i = 1'b0;
    logic  ready_o = 1'b0;
    tile_t tin = '0;
    logic  ready_i;
    logic  valid_o;
    tile_t tout;

    always #5 clk = ~clk;

    pyramid_downsample_pack #(.D(4), .W(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .valid_i (valid_i),
        .ready_i (ready_i),
        .in      (tin),
        .valid_o (valid_o),
        .ready_o (ready_o),
        .out     (tout)
    );

    int    n_cmp  = 0;
    int    n_fail = 0;
    tile_t exp_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic tile_t mk(input int k);
        tile_t t;
        for (int p = 0; p < 16; p++) t[p] = 8'(16*k + p);
        return t;
    endfunction

    function automatic logic [7:0] dsm(input tile_t t, input int i, input int j);
`ifdef PYRAMID_DOWNSAMPLE_AVG_EN
        logic [9:0] s;
        s = 10'(t[2*i*4+2*j]) + 10'(t[2*i*4+2*j+1]) + 10'(t[(2*i+1)*4+2*j])
          + 10'(t[(2*i+1)*4+2*j+1]) + 10'd2;
        return s[9:2];
`else
        return t[2*i*4+2*j];
`endif
    endfunction

    function automatic tile_t pack4(input tile_t a, input tile_t b, input tile_t c, input tile_t d);
        tile_t o, s;
        for (int q = 0; q < 4; q++) begin
            case (q)
                0: s = a;
                1: s = b;
                2: s = c;
                default: s = d;
            endcase
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 2; j++)
                    o[((q/2)*2+i)*4 + (q%2)*2 + j] = dsm(s, i, j);
        end
        return o;
    endfunction

    task automatic send(input tile_t t);
        int guard = 0;
        valid_i = 1'b1;
        tin     = t;
        @(negedge clk);
        while (!ready_i && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: ready_i stuck at %0b, required 1", ready_i);
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    // Scoreboard monitor: every output transaction pops one expected tile.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && valid_o && ready_o) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL out_unexpected: got tile %h, required no output", tout);
                end else begin
                    chk("out_tile", tout, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int    e1[16] = '{0,2,16,18, 8,10,24,26, 32,34,48,50, 40,42,56,58};
        bit    pat[7] = '{1,0,0,1,0,1,1};
        tile_t t1;
        tile_t ones;
        tile_t held;
        int    off;
        int    idx;

`ifdef PYRAMID_DOWNSAMPLE_AVG_EN
        off = 3;
`else
        off = 0;
`endif
        for (int p = 0; p < 16; p++) t1[p] = 8'(e1[p] + off);
        ones = '1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_valid_o", 128'(valid_o), 128'd0);
        chk("rst_ready_i", 128'(ready_i), 128'd1);
        chk("rst_out", tout, 128'd0);

        // Four back-to-back tiles, hand-computed result
        @(posedge clk); #1;
        ready_o = 1'b1;
        exp_q.push_back(t1);
        for (int k = 0; k < 4; k++) send(mk(k));
        @(negedge clk);
        chk("t1_valid_hi", 128'(valid_o), 128'd1);
        @(negedge clk);
        chk("t1_valid_lo", 128'(valid_o), 128'd0);

        // All-255 tiles: no overflow in either build
        @(posedge clk); #1;
        exp_q.push_back(ones);
        for (int k = 0; k < 4; k++) send(ones);
        @(negedge clk);
        chk("ff_valid_hi", 128'(valid_o), 128'd1);

        // Backpressure with a held 5th tile, then same-cycle drain/refill
        @(posedge clk); #1;
        ready_o = 1'b0;
        held = pack4(mk(4), mk(5), mk(6), mk(7));
        exp_q.push_back(held);
        for (int k = 4; k < 8; k++) send(mk(k));
        valid_i = 1'b1;
        tin     = mk(8);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_valid_o", 128'(valid_o), 128'd1);
            chk("bp_ready_i", 128'(ready_i), 128'd0);
            chk("bp_out", tout, held);
            @(posedge clk); #1;
        end
        ready_o = 1'b1;
        exp_q.push_back(pack4(mk(8), mk(9), mk(10), mk(11)));
        @(negedge clk);
        chk("bp_refill_ready", 128'(ready_i), 128'd1);
        @(posedge clk); #1;
        valid_i = 1'b0;
        for (int k = 9; k < 12; k++) send(mk(k));
        @(negedge clk);
        chk("bp_q1_valid_hi", 128'(valid_o), 128'd1);
        @(negedge clk);
        chk("bp_q1_valid_lo", 128'(valid_o), 128'd0);

        // Bubbles in valid_i
        @(posedge clk); #1;
        exp_q.push_back(pack4(mk(12), mk(13), mk(14), mk(15)));
        idx = 0;
        for (int c = 0; c < 7; c++) begin
            valid_i = pat[c];
            tin     = mk(12 + idx);
            @(negedge clk);
            chk("bub_valid_lo", 128'(valid_o), 128'd0);
            @(posedge clk); #1;
            if (pat[c]) idx++;
        end
        valid_i = 1'b0;
        @(negedge clk);
        chk("bub_valid_hi", 128'(valid_o), 128'd1);
        @(negedge clk);
        chk("bub_valid_end", 128'(valid_o), 128'd0);

        // Reset mid-fill
        @(posedge clk); #1;
        ready_o = 1'b0;
        send(mk(1));
        send(mk(2));
        reset = 1'b1;
        @(negedge clk);
        chk("rmf_valid_in", 128'(valid_o), 128'd0);
        chk("rmf_ready_in", 128'(ready_i), 128'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rmf_valid_after", 128'(valid_o), 128'd0);
        chk("rmf_ready_after", 128'(ready_i), 128'd1);
        chk("rmf_out_after", tout, 128'd0);
        @(posedge clk); #1;
        ready_o = 1'b1;
        exp_q.push_back(pack4(mk(20), mk(21), mk(22), mk(23)));
        for (int k = 20; k < 24; k++) send(mk(k));
        @(negedge clk);
        chk("rmf_valid_hi", 128'(valid_o), 128'd1);

        // Reset while FULL and stalled: tile dropped, no output txn
        @(posedge clk); #1;
        ready_o = 1'b0;
        for (int k = 24; k < 28; k++) send(mk(k));
        @(negedge clk);
        chk("rf_valid_full", 128'(valid_o), 128'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rf_valid_lo", 128'(valid_o), 128'd0);
        chk("rf_out_zero", tout, 128'd0);
        @(posedge clk); #1;
        ready_o = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rf_no_output", 128'(valid_o), 128'd0);
        end

        chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
